// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce emulator: FSM encoding, LFSR geometry and step.
package bounce_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned TAP_A  = 7;
  localparam int unsigned TAP_B  = 5;
  localparam int unsigned TAP_C  = 4;
  localparam int unsigned TAP_D  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // One Fibonacci step: shift left, feedback from taps {7,5,4,3} into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit LFSR noise source with enable and synchronous load; seeded on reset.
module lfsr8
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_state,
  output logic [LFSR_W-1:0] o_next_c
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state  = r_state;
  assign o_next_c = lfsr_step(r_state);

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: chatters on o_out for BOUNCE_CYCLES, then holds the new level.
// Optional macro BOUNCE_GLITCH_LIMIT_EN limits every excursion to a single cycle.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned       BOUNCE_CYCLES = 8,
  parameter int unsigned       SETTLE_CYCLES = 4,
  parameter int unsigned       CNT_W         = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_level_in,
  output logic o_out,
  output logic o_busy,
  output logic o_done
);

  // Configuration sanity: counter must reach both terminal counts, seed must not lock up.
  if (BOUNCE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
    $error("bounce_gen: BOUNCE_CYCLES and SETTLE_CYCLES must be >= 1");
  end
  if ((BOUNCE_CYCLES - 1) >= (1 << CNT_W) || (SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("bounce_gen: CNT_W too narrow for BOUNCE_CYCLES/SETTLE_CYCLES");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("bounce_gen: LFSR_SEED must be non-zero");
  end

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_out, w_out_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_stable, w_stable_nxt;
  logic               r_target, w_target_nxt;

  logic [LFSR_W-1:0]  w_lfsr;
  logic [LFSR_W-1:0]  w_lfsr_next;
  logic               w_unused;
  logic               w_noise;
  logic               w_bounce_out;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == ST_BOUNCE),
    .i_load   (1'b0),
    .i_seed   (LFSR_SEED),
    .o_state  (w_lfsr),
    .o_next_c (w_lfsr_next)
  );

  assign w_unused = ^{w_lfsr[LFSR_W-1:1], w_lfsr_next[LFSR_W-1:1]};

  // Noise for the next bounce cycle: current LFSR at acceptance, advanced LFSR afterwards.
  assign w_noise = (r_state == ST_IDLE) ? w_lfsr[0] : w_lfsr_next[0];

`ifdef BOUNCE_GLITCH_LIMIT_EN
  logic r_exc, w_exc_nxt;
  logic w_prev_exc;
  logic w_exc;

  assign w_prev_exc   = (r_state == ST_IDLE) ? 1'b0 : r_exc;
  assign w_exc        = w_noise & ~w_prev_exc;
  assign w_bounce_out = r_stable ^ w_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc <= 1'b0;
    end else begin
      r_exc <= w_exc_nxt;
    end
  end
`else
  assign w_bounce_out = w_noise;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_stable <= 1'b0;
      r_target <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_stable <= w_stable_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_done_nxt   = 1'b0;
    w_stable_nxt = r_stable;
    w_target_nxt = r_target;
`ifdef BOUNCE_GLITCH_LIMIT_EN
    w_exc_nxt    = 1'b0;
`endif

    unique case (r_state)
      ST_IDLE: begin
        w_out_nxt = r_stable;
        if (i_start && (i_level_in != r_stable)) begin
          w_target_nxt = i_level_in;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_BOUNCE;
          w_out_nxt    = w_bounce_out;
`ifdef BOUNCE_GLITCH_LIMIT_EN
          w_exc_nxt    = w_exc;
`endif
        end
      end

      ST_BOUNCE: begin
        if (r_cnt == BOUNCE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
          w_out_nxt   = r_target;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_out_nxt   = w_bounce_out;
`ifdef BOUNCE_GLITCH_LIMIT_EN
          w_exc_nxt   = w_exc;
`endif
        end
      end

      ST_SETTLE: begin
        w_out_nxt = r_target;
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_IDLE;
          w_stable_nxt = r_target;
          w_done_nxt   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: vector tables for full requests, hand sequences for reset abort.
module tb_bounce_gen;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic i_level_in;
  logic o_out;
  logic o_busy;
  logic o_done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic start;
    logic level;
    logic exp_out;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t vecs[$];

  // Chatter seen on o_out: first request from seed A5, second from 4E (the LFSR after A7).
`ifdef BOUNCE_GLITCH_LIMIT_EN
  logic [0:7] b1 = 8'b10100101;
  logic [0:7] b2 = 8'b10101011;
`else
  logic [0:7] b1 = 8'b10100111;
  logic [0:7] b2 = 8'b01110110;
`endif

  bounce_gen dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_level_in (i_level_in),
    .o_out      (o_out),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic l, input logic eo, input logic eb, input logic ed);
    vec_t v;
    v.start    = s;
    v.level    = l;
    v.exp_out  = eo;
    v.exp_busy = eb;
    v.exp_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      i_start    = vecs[i].start;
      i_level_in = vecs[i].level;
      tick();
      chk($sformatf("%s[%0d].out", tag, i),  o_out,  vecs[i].exp_out);
      chk($sformatf("%s[%0d].busy", tag, i), o_busy, vecs[i].exp_busy);
      chk($sformatf("%s[%0d].done", tag, i), o_done, vecs[i].exp_done);
    end
    vecs.delete();
    i_start    = 1'b0;
    i_level_in = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    i_start    = 1'b0;
    i_level_in = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    chk("rst.out",  o_out,  1'b0);
    chk("rst.busy", o_busy, 1'b0);
    chk("rst.done", o_done, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst.out",  o_out,  1'b0);
    chk("post_rst.busy", o_busy, 1'b0);

    // Ignored request, then request to 1 with start/level noise during busy.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, b1[0], 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      add((k == 3) || (k == 6), 1'(k % 2), b1[k], 1'b1, 1'b0);
    end
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_table("req1");

    // Request to 0, aborted by reset in the 3rd bounce cycle.
    i_start    = 1'b1;
    i_level_in = 1'b0;
    tick();
    i_start    = 1'b0;
    chk("abort.k0.busy", o_busy, 1'b1);
    tick();
    tick();
    chk("abort.k2.out",  o_out,  1'b1);
    chk("abort.k2.busy", o_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.async.out",  o_out,  1'b0);
    chk("abort.async.busy", o_busy, 1'b0);
    chk("abort.async.done", o_done, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.hold.done", o_done, 1'b0);
    tick();
    chk("abort.idle.out",  o_out,  1'b0);
    chk("abort.idle.busy", o_busy, 1'b0);
    chk("abort.idle.done", o_done, 1'b0);

    // Back-to-back: chatter restarts from seed, second request accepted in the done cycle.
    add(1'b1, 1'b1, b1[0], 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 1'b0, b1[k], 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, b2[0], 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 1'b1, b2[k], 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_table("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
